veda_port_arbiter: RTL and testbench

//  Shares one VEDA memory port between two requesters: instruction fetch (IF,

---
 rtl/veda_port_arbiter.sv | 111 +++++++++++
 tb/tb_veda_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/veda_port_arbiter.sv
// veda_port_arbiter: shares one VEDA memory port between instruction fetch (IF)
// and load/store (LS). Grants are combinational, read returns are steered back
// to their issuer through a RD_LATENCY-deep tag pipe.
// Optional build macro: VEDA_ARB_FAIRNESS_EN adds an IF starvation counter that
// forces an IF win after STARVE_MAX consecutive denials.
module veda_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              VEDA_mode,
    output logic [ADDR_W-1:0] VEDA_address,
    output logic [DATA_W-1:0] VEDA_data_in,
    input  logic [DATA_W-1:0] VEDA_data_out
);

    // owner: 1 = LS, 0 = IF
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    tag_t tag_q [RD_LATENCY];
    logic if_force;
    logic rd_push;

`ifdef VEDA_ARB_FAIRNESS_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q;

    assign if_force = (starve_q == CNT_W'(STARVE_MAX));

    // Count consecutive cycles IF waits; saturates so IF keeps winning until served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (!if_req || if_gnt) begin
            starve_q <= '0;
        end else if (!if_force) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end
`else
    assign if_force = 1'b0;
`endif

    // Arbitration: LS wins unless IF has been starved; nothing granted in reset.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst) begin
            if_gnt = if_req && (!ls_req || if_force);
            ls_gnt = ls_req && !(if_req && if_force);
        end
    end

    // Winner drives the VEDA lines; idle lines sit at read/zero.
    always_comb begin
        VEDA_mode    = 1'b1;
        VEDA_address = '0;
        VEDA_data_in = '0;
        if (ls_gnt) begin
            VEDA_mode    = !ls_we;
            VEDA_address = ls_addr;
            VEDA_data_in = ls_we ? ls_wdata : '0;
        end else if (if_gnt) begin
            VEDA_address = if_addr;
        end
    end

    assign rd_push = (ls_gnt && !ls_we) || if_gnt;

    // Tag pipe: one stage per cycle of read latency, writes push an empty tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: rd_push, owner: ls_gnt};
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Return steering from the oldest tag.
    always_comb begin
        if_rvalid = tag_q[RD_LATENCY-1].valid && !tag_q[RD_LATENCY-1].owner;
        ls_rvalid = tag_q[RD_LATENCY-1].valid &&  tag_q[RD_LATENCY-1].owner;
        if_rdata  = if_rvalid ? VEDA_data_out : '0;
        ls_rdata  = ls_rvalid ? VEDA_data_out : '0;
    end

endmodule

// File: tb/tb_veda_port_arbiter.sv
// Bench for veda_port_arbiter: random and directed traffic, grant/port checks
// per cycle, read returns checked by a scoreboard against a reference memory.
module tb_veda_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 3;
    localparam int unsigned SMAX = 4;
`ifdef VEDA_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [DW-1:0] if_rdata, ls_rdata;
    logic          VEDA_mode;
    logic [AW-1:0] VEDA_address;
    logic [DW-1:0] VEDA_data_in, VEDA_data_out;

    veda_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .VEDA_mode(VEDA_mode), .VEDA_address(VEDA_address),
        .VEDA_data_in(VEDA_data_in), .VEDA_data_out(VEDA_data_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // Memory environment: fixed-latency read pipe, write on mode=0.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    always @(posedge clk) begin
        if (!VEDA_mode) mem[VEDA_address] = VEDA_data_in;
        rd_pipe[0] <= mem.exists(VEDA_address) ? mem[VEDA_address] : mem_init(VEDA_address);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign VEDA_data_out = rd_pipe[LAT-1];

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int starve = 0;
    typedef struct {
        int unsigned   due;
        logic          owner;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_ls_gnt", 64'(ls_gnt), 64'd0);
        chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("rst_ls_rvalid", 64'(ls_rvalid), 64'd0);
        chk("rst_rdata", {if_rdata, ls_rdata}, 64'd0);
        chk("rst_mode", 64'(VEDA_mode), 64'd1);
        chk("rst_addr", 64'(VEDA_address), 64'd0);
        chk("rst_din", 64'(VEDA_data_in), 64'd0);
    endtask

    // One arbitration cycle: drive, predict from the rules, check, queue returns.
    task automatic cycle(input logic ir, input logic [AW-1:0] ia,
                         input logic lr, input logic lwe, input logic [AW-1:0] la,
                         input logic [DW-1:0] lw, output logic ig, output logic lg);
        logic          e_mode;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lwe; ls_addr = la; ls_wdata = lw;
        ig = ir && (!lr || (FAIR && starve >= int'(SMAX)));
        lg = lr && !ig;
        e_mode = !(lg && lwe);
        e_addr = lg ? la : (ig ? ia : '0);
        e_din  = (lg && lwe) ? lw : '0;
        @(negedge clk);
        chk("if_gnt", 64'(if_gnt), 64'(ig));
        chk("ls_gnt", 64'(ls_gnt), 64'(lg));
        chk("veda_mode", 64'(VEDA_mode), 64'(e_mode));
        chk("veda_addr", 64'(VEDA_address), 64'(e_addr));
        chk("veda_din", 64'(VEDA_data_in), 64'(e_din));
        if (lg && !lwe) sbq.push_back('{due: cyc + LAT, owner: 1'b1, data: ref_rd(la)});
        if (lg && lwe)  ref_mem[la] = lw;
        if (ig)         sbq.push_back('{due: cyc + LAT, owner: 1'b0, data: ref_rd(ia)});
        if (ir && !ig) starve = (starve < int'(SMAX)) ? starve + 1 : starve;
        else           starve = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        sbq.delete();
        starve = 0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    endtask

    // Monitor: pop and compare whenever a return is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_rvalid || ls_rvalid) begin
                    chk("rvalid_onehot", 64'(if_rvalid && ls_rvalid), 64'd0);
                    if (sbq.size() == 0) begin
                        chk("unexpected_rvalid", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ret_cycle", 64'(cyc), 64'(e.due));
                        chk("ret_owner", 64'(ls_rvalid), 64'(e.owner));
                        chk("ret_data", 64'(ls_rvalid ? ls_rdata : if_rdata), 64'(e.data));
                        chk("ret_other_rdata", 64'(ls_rvalid ? if_rdata : ls_rdata), 64'd0);
                    end
                end else begin
                    if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                        e = sbq.pop_front();
                        chk("missing_rvalid", 64'(cyc), 64'(e.due + 1000));
                    end
                    chk("idle_rdata", {if_rdata, ls_rdata}, 64'd0);
                end
            end
        end
    end

    initial begin
        logic ig, lg;
        logic ir, lr, lwe;
        logic [AW-1:0] ia, la;
        logic [DW-1:0] lw;
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone fetch
        mem[32'h10] = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        cycle(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, ig, lg);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, ig, lg);
        // Contention, then LS drops and the held IF request goes through
        cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h20, '0, ig, lg);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, ig, lg);
        // Store then fetch of the same address
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h30, 32'h1234, ig, lg);
        cycle(1'b1, 32'h30, 1'b0, 1'b0, '0, '0, ig, lg);
        // Continuous contention: starvation behaviour
        for (int n = 0; n < 12; n++)
            cycle(1'b1, 32'h44, 1'b1, 1'b0, 32'(n * 4), '0, ig, lg);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, ig, lg);
        // Read in flight dropped by reset
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, '0, ig, lg);
        do_reset();

        // Random traffic obeying the hold-until-granted rule
        ir = 1'b0; lr = 1'b0; lwe = 1'b0; ia = '0; la = '0; lw = '0;
        ig = 1'b1; lg = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!(ir && !ig)) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = 32'($urandom_range(0, 15) * 4);
            end
            if (!(lr && !lg)) begin
                lr  = ($urandom_range(0, 2) != 0);
                lwe = ($urandom_range(0, 2) == 0);
                la  = 32'($urandom_range(0, 15) * 4);
                lw  = $urandom;
            end
            cycle(ir, ia, lr, lwe, la, lw, ig, lg);
            if (n == 200) begin
                do_reset();
                ir = 1'b0; lr = 1'b0; ig = 1'b1; lg = 1'b1;
            end
        end

        // Drain
        for (int n = 0; n < int'(LAT) + 2; n++)
            cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, ig, lg);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
